// File: rtl/hsst_pkt_pkg.sv
// Shared constants for the HSST packet transmitter: K-characters, control
// words and the framing FSM state encoding.
package hsst_pkt_pkg;

    localparam logic [7:0]  K28_5     = 8'hBC;   // comma / idle
    localparam logic [7:0]  K27_7     = 8'hFB;   // start of packet
    localparam logic [7:0]  K29_7     = 8'hFD;   // end of packet

    localparam logic [31:0] IDLE_WORD = {24'h00_0000, K28_5};

    // Only byte 0 of a control word is a K-character
    localparam logic [3:0]  TXK_CTRL  = 4'b0001;
    localparam logic [3:0]  TXK_DATA  = 4'b0000;

    // Each state names the word class currently on txdata
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StSof  = 2'd1,
        StData = 2'd2,
        StEof  = 2'd3
    } state_t;

endpackage

// File: rtl/hsst_fifo_pkt_tx.sv
// HSST line-FIFO read-side packetiser. Drains LINE_WORDS-word lines from the
// FIFO and frames them as SOF, payload, EOF(checksum); sends comma idles
// otherwise. FIFO read data arrives one cycle after fifo_rd_en, so the
// payload reaches txdata two cycles after the read that fetched it.
module hsst_fifo_pkt_tx
    import hsst_pkt_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned DEPTH_WIDTH = 10,
    parameter int unsigned LINE_WORDS  = 640
) (
    input  logic                   i_rd_clk,
    input  logic                   i_rd_rst,
    output logic                   o_fifo_rd_en,
    input  logic [DATA_WIDTH-1:0]  i_fifo_rd_data,
    input  logic                   i_fifo_rd_empty,
    input  logic [DEPTH_WIDTH:0]   i_fifo_rd_water_level,
    input  logic                   i_frame_start,
    input  logic                   i_link_ready,
    output logic [DATA_WIDTH-1:0]  o_txdata,
    output logic [3:0]             o_txk,
    output logic [15:0]            o_line_cnt,
    output logic                   o_busy,
    output logic                   o_underflow
);

    localparam int unsigned        CNT_W      = $clog2(LINE_WORDS + 1);
    // Counter value on the last DATA cycle, i.e. when EOF gets loaded
    localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(LINE_WORDS);
    // Reads after the start cycle continue while the counter is below this
    localparam logic [CNT_W-1:0]   CNT_RD_END = CNT_W'(LINE_WORDS - 1);
    localparam logic [DEPTH_WIDTH:0] LVL_MIN  = (DEPTH_WIDTH + 1)'(LINE_WORDS);

    state_t                 r_state, w_state_d;
    logic [CNT_W-1:0]       r_cnt, w_cnt_d;
    logic [23:0]            r_chk, w_chk_d;
    logic [15:0]            r_line_cnt, w_line_cnt_d;
    logic                   r_pend, w_pend_d;
    logic                   r_underflow;
    logic [DATA_WIDTH-1:0]  r_txdata, w_txdata_d;
    logic [3:0]             r_txk, w_txk_d;
    logic                   w_start;
    logic                   w_rd_more;
    logic                   w_pend;

    // Packet start qualification and combinational read enable / busy
    always_comb begin
        w_start      = !i_rd_rst && (r_state == StIdle || r_state == StEof) &&
                       i_link_ready && (i_fifo_rd_water_level >= LVL_MIN);
        w_rd_more    = !i_rd_rst && (r_state == StSof || r_state == StData) &&
                       (r_cnt < CNT_RD_END);
        o_fifo_rd_en = w_start || w_rd_more;
        o_busy       = !i_rd_rst && (w_start || r_state != StIdle);
    end

    // Line numbering: a pending frame_start zeroes the count at the next
    // EOF or IDLE cycle so an SOF already sent keeps its number
    always_comb begin
        w_pend       = r_pend || i_frame_start;
        w_pend_d     = w_pend;
        w_line_cnt_d = r_line_cnt;
        if (r_state == StIdle || r_state == StEof) begin
            if (w_pend) begin
                w_line_cnt_d = 16'h0000;
                w_pend_d     = 1'b0;
            end else if (r_state == StEof) begin
                w_line_cnt_d = r_line_cnt + 16'd1;
            end
        end
    end

    // Framing FSM next state, word counter, checksum and next tx word
    always_comb begin
        w_state_d  = r_state;
        w_cnt_d    = r_cnt;
        w_chk_d    = r_chk;
        w_txdata_d = IDLE_WORD;
        w_txk_d    = TXK_CTRL;
        case (r_state)
            StIdle, StEof: begin
                if (w_start) begin
                    w_state_d  = StSof;
                    w_cnt_d    = '0;
                    w_txdata_d = {w_line_cnt_d, 8'h00, K27_7};
                end else begin
                    w_state_d  = StIdle;
                end
            end
            StSof: begin
                // Word 0 is on the read port now; checksum restarts here
                w_state_d  = StData;
                w_cnt_d    = r_cnt + CNT_W'(1);
                w_chk_d    = i_fifo_rd_data[23:0];
                w_txdata_d = i_fifo_rd_data;
                w_txk_d    = TXK_DATA;
            end
            StData: begin
                if (r_cnt == CNT_LAST) begin
                    w_state_d  = StEof;
                    w_txdata_d = {r_chk, K29_7};
                end else begin
                    w_cnt_d    = r_cnt + CNT_W'(1);
                    w_chk_d    = r_chk ^ i_fifo_rd_data[23:0];
                    w_txdata_d = i_fifo_rd_data;
                    w_txk_d    = TXK_DATA;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge i_rd_clk) begin
        if (i_rd_rst) begin
            r_state     <= StIdle;
            r_cnt       <= '0;
            r_chk       <= '0;
            r_line_cnt  <= '0;
            r_pend      <= 1'b0;
            r_underflow <= 1'b0;
            r_txdata    <= IDLE_WORD;
            r_txk       <= TXK_CTRL;
        end else begin
            r_state     <= w_state_d;
            r_cnt       <= w_cnt_d;
            r_chk       <= w_chk_d;
            r_line_cnt  <= w_line_cnt_d;
            r_pend      <= w_pend_d;
            r_underflow <= r_underflow || (o_fifo_rd_en && i_fifo_rd_empty);
            r_txdata    <= w_txdata_d;
            r_txk       <= w_txk_d;
        end
    end

    assign o_txdata    = r_txdata;
    assign o_txk       = r_txk;
    assign o_line_cnt  = r_line_cnt;
    assign o_underflow = r_underflow;

endmodule

// File: tb/tb_hsst_fifo_pkt_tx.sv
// Bench for hsst_fifo_pkt_tx with LINE_WORDS=4: a queue-backed FIFO model,
// a schedule-based reference of the expected line stream, a table of
// expected cycles for one packet, and directed corner-case sequences.
module tb_hsst_fifo_pkt_tx;

    localparam int L  = 4;
    localparam int DW = 10;

    logic        clk = 1'b0;
    logic        rst, fs, link, empty, en, busy, uf;
    logic [31:0] rdd, txd;
    logic [3:0]  txk;
    logic [DW:0] lvl;
    logic [15:0] line;

    always #5 clk = ~clk;

    hsst_fifo_pkt_tx #(
        .DATA_WIDTH  (32),
        .DEPTH_WIDTH (DW),
        .LINE_WORDS  (L)
    ) u_dut (
        .i_rd_clk              (clk),
        .i_rd_rst              (rst),
        .o_fifo_rd_en          (en),
        .i_fifo_rd_data        (rdd),
        .i_fifo_rd_empty       (empty),
        .i_fifo_rd_water_level (lvl),
        .i_frame_start         (fs),
        .i_link_ready          (link),
        .o_txdata              (txd),
        .o_txk                 (txk),
        .o_line_cnt            (line),
        .o_busy                (busy),
        .o_underflow           (uf)
    );

    int checks = 0;
    int errors = 0;

    // FIFO contents and reference-model state
    logic [31:0] fq[$];
    logic [35:0] exp_tx[int];   // {txk, txdata} scheduled per cycle
    int          cyc = 0;
    bit          pk_valid = 0;
    int          pk_s = 0;
    logic [15:0] m_line = 0;
    bit          m_pend = 0, m_uf = 0, m_known = 0;

    // Samples of the current cycle
    logic        s_en, s_busy, s_uf;
    logic [31:0] s_tx;
    logic [3:0]  s_k;
    logic [15:0] s_line;

    typedef struct {
        bit          link;
        bit          fs;
        bit          x_en;
        bit          x_busy;
        logic [3:0]  x_k;
        logic [31:0] x_tx;
    } vec_t;
    vec_t tbl[8];

    task automatic chk(input string nm, input logic [35:0] act, input logic [35:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    function automatic logic [35:0] expect_tx(input int c);
        if (exp_tx.exists(c)) return exp_tx[c];
        return {4'b0001, 32'h0000_00BC};
    endfunction

    // One clock cycle: drive inputs, sample at negedge, check against the
    // reference schedule, then model the FIFO's one-cycle read latency.
    task automatic step(input bit r, input bit f, input bit lk, input bit eo);
        logic [15:0] nl;
        logic [23:0] ck;
        bit          pend, free, start, xen, xbusy;
        int          dead[$];
        rst   = r;
        fs    = f;
        link  = lk;
        lvl   = (DW + 1)'(fq.size());
        empty = eo || (fq.size() == 0);
        @(negedge clk);
        s_en = en; s_busy = busy; s_uf = uf; s_tx = txd; s_k = txk; s_line = line;
        if (m_known) begin
            chk("txdata", {s_k, s_tx}, expect_tx(cyc));
            chk("line_cnt", {20'h0, s_line}, {20'h0, m_line});
            chk("underflow", {35'h0, s_uf}, {35'h0, m_uf});
        end
        if (r) begin
            chk("rst_rd_en", {35'h0, s_en}, 36'h0);
            chk("rst_busy", {35'h0, s_busy}, 36'h0);
            m_line = 0; m_pend = 0; m_uf = 0; pk_valid = 0; m_known = 1;
            foreach (exp_tx[k]) if (k > cyc) dead.push_back(k);
            foreach (dead[i]) exp_tx.delete(dead[i]);
        end else begin
            pend  = m_pend || f;
            free  = !pk_valid || (cyc >= pk_s + L + 2);
            nl    = m_line;
            if (free) begin
                if (pend) begin
                    nl   = 16'h0;
                    pend = 0;
                end else if (pk_valid && cyc == pk_s + L + 2) begin
                    nl = m_line + 16'd1;
                end
            end
            start = free && lk && (fq.size() >= L);
            if (start) begin
                pk_valid = 1;
                pk_s     = cyc;
                exp_tx[cyc + 1] = {4'b0001, nl, 8'h00, 8'hFB};
                ck = 24'h0;
                for (int k = 0; k < L; k++) begin
                    exp_tx[cyc + 2 + k] = {4'b0000, fq[k]};
                    ck ^= fq[k][23:0];
                end
                exp_tx[cyc + L + 2] = {4'b0001, ck, 8'hFD};
            end
            xen   = pk_valid && cyc >= pk_s && cyc < pk_s + L;
            xbusy = pk_valid && cyc >= pk_s && cyc <= pk_s + L + 2;
            chk("rd_en", {35'h0, s_en}, {35'h0, xen});
            chk("busy", {35'h0, s_busy}, {35'h0, xbusy});
            if (xen && empty) m_uf = 1;
            m_line = nl;
            m_pend = pend;
        end
        if (exp_tx.exists(cyc)) exp_tx.delete(cyc);
        @(posedge clk);
        #1;
        if (s_en) rdd = (fq.size() > 0) ? fq.pop_front() : $urandom();
        cyc++;
    endtask

    task automatic do_reset();
        fq.delete();
        step(1, 0, 1, 0);
        step(1, 0, 1, 0);
    endtask

    // Step until rd_en is seen; that cycle is the start cycle S
    task automatic find_start(output bit found);
        found = 0;
        for (int i = 0; i < 12 && !found; i++) begin
            step(0, 0, 1, 0);
            if (s_en) found = 1;
        end
        chk("start_seen", {35'h0, found}, 36'h1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          found, seen_fd;
        int          a, b, lows, highs, sof_n, fd_n, bc_n, idx_sof0, idx_eof1;
        logic [31:0] sof2, next_sof;
        logic [31:0] tx_h[24];
        logic [3:0]  k_h[24];
        bit          en_h[24];

        rst = 1; fs = 0; link = 1; empty = 1; lvl = '0; rdd = '0;

        tbl[0] = '{1, 0, 1, 1, 4'b0001, 32'h0000_00BC};
        tbl[1] = '{1, 0, 1, 1, 4'b0001, 32'h0000_00FB};
        tbl[2] = '{1, 0, 1, 1, 4'b0000, 32'h0000_0001};
        tbl[3] = '{1, 0, 1, 1, 4'b0000, 32'h0000_0002};
        tbl[4] = '{1, 0, 0, 1, 4'b0000, 32'h0000_0003};
        tbl[5] = '{1, 0, 0, 1, 4'b0000, 32'h0000_0004};
        tbl[6] = '{1, 0, 0, 1, 4'b0001, 32'h0000_04FD};
        tbl[7] = '{1, 0, 0, 0, 4'b0001, 32'h0000_00BC};

        // Reset values and a level one short of a line
        do_reset();
        chk("reset_tx", {s_k, s_tx}, {4'b0001, 32'h0000_00BC});
        chk("reset_line", {20'h0, s_line}, 36'h0);
        fq.push_back(32'd1); fq.push_back(32'd2); fq.push_back(32'd3);
        for (int i = 0; i < 8; i++) begin
            step(0, 0, 1, 0);
            chk("short_level_rd_en", {35'h0, s_en}, 36'h0);
        end
        chk("short_level_tx", {s_k, s_tx}, {4'b0001, 32'h0000_00BC});

        // One packet, checked cycle by cycle against the table
        fq.push_back(32'd4);
        for (int i = 0; i < 8; i++) begin
            step(0, tbl[i].fs, tbl[i].link, 0);
            chk("tbl_rd_en", {35'h0, s_en}, {35'h0, tbl[i].x_en});
            chk("tbl_busy", {35'h0, s_busy}, {35'h0, tbl[i].x_busy});
            chk("tbl_tx", {s_k, s_tx}, {tbl[i].x_k, tbl[i].x_tx});
        end
        chk("line_after_eof", {20'h0, s_line}, 36'h1);

        // Back-to-back packets
        do_reset();
        for (int i = 0; i < 8; i++) fq.push_back(32'h100 + 32'(i));
        for (int i = 0; i < 24; i++) begin
            step(0, 0, 1, 0);
            en_h[i] = s_en; tx_h[i] = s_tx; k_h[i] = s_k;
        end
        a = -1; b = -1; lows = 0; highs = 0; sof_n = 0; fd_n = 0; bc_n = 0;
        idx_sof0 = -1; idx_eof1 = -1; sof2 = '0;
        for (int i = 0; i < 24; i++) if (en_h[i]) begin if (a < 0) a = i; b = i; end
        if (a >= 0) for (int i = a; i <= b; i++) if (en_h[i]) highs++; else lows++;
        for (int i = 0; i < 24; i++) begin
            if (k_h[i] == 4'b0001 && tx_h[i][7:0] == 8'hFB) begin
                sof_n++;
                if (sof_n == 1) idx_sof0 = i;
                if (sof_n == 2) sof2 = tx_h[i];
            end
            if (k_h[i] == 4'b0001 && tx_h[i][7:0] == 8'hFD) begin
                fd_n++;
                if (fd_n == 2) idx_eof1 = i;
            end
        end
        if (idx_sof0 >= 0 && idx_eof1 > idx_sof0)
            for (int i = idx_sof0; i < idx_eof1; i++) if (tx_h[i] == 32'h0000_00BC) bc_n++;
        chk("b2b_rd_en_high", 36'(highs), 36'd8);
        chk("b2b_rd_en_gap", 36'(lows), 36'd2);
        chk("b2b_second_sof", {4'h0, sof2}, {4'h0, 32'h0001_00FB});
        chk("b2b_eofs", 36'(fd_n), 36'd2);
        chk("b2b_span_ok", {35'h0, (idx_sof0 >= 0 && idx_eof1 > idx_sof0)}, 36'h1);
        chk("b2b_no_idle", 36'(bc_n), 36'd0);

        // frame_start during DATA of line 5
        do_reset();
        for (int i = 0; i < 28; i++) fq.push_back($urandom());
        found = 0;
        for (int i = 0; i < 60 && !found; i++) begin
            step(0, 0, 1, 0);
            if (s_k == 4'b0001 && s_tx == 32'h0005_00FB) found = 1;
        end
        chk("line5_sof_seen", {35'h0, found}, 36'h1);
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        step(0, 1, 1, 0);
        seen_fd = 0; found = 0; next_sof = '0;
        for (int i = 0; i < 12 && !found; i++) begin
            step(0, 0, 1, 0);
            if (s_k == 4'b0001 && s_tx[7:0] == 8'hFD) seen_fd = 1;
            if (s_k == 4'b0001 && s_tx[7:0] == 8'hFB) begin found = 1; next_sof = s_tx; end
        end
        chk("fs_eof_sent", {35'h0, seen_fd}, 36'h1);
        chk("fs_next_sof", {4'h0, next_sof}, {4'h0, 32'h0000_00FB});

        // Underflow on the third read
        do_reset();
        for (int i = 0; i < 4; i++) fq.push_back(32'hA0 + 32'(i));
        find_start(found);
        step(0, 0, 1, 0);
        step(0, 0, 1, 1);
        chk("uf_third_read_en", {35'h0, s_en}, 36'h1);
        step(0, 0, 1, 0);
        chk("uf_set", {35'h0, s_uf}, 36'h1);
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        chk("uf_eof_at_s6", {s_k, 24'h0, s_tx[7:0]}, {4'b0001, 24'h0, 8'hFD});
        for (int i = 0; i < 4; i++) fq.push_back(32'hB0 + 32'(i));
        fd_n = 0;
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 1, 0);
            if (s_k == 4'b0001 && s_tx[7:0] == 8'hFD) fd_n++;
        end
        chk("uf_next_pkt_eof", 36'(fd_n), 36'd1);
        chk("uf_sticky", {35'h0, s_uf}, 36'h1);
        do_reset();
        step(0, 0, 1, 0);
        chk("uf_cleared", {35'h0, s_uf}, 36'h0);

        // Reset at S+3 abandons the packet
        do_reset();
        for (int i = 0; i < 4; i++) fq.push_back(32'hC0 + 32'(i));
        find_start(found);
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        step(1, 0, 1, 0);
        chk("rst_mid_rd_en", {35'h0, s_en}, 36'h0);
        step(0, 0, 1, 0);
        chk("rst_mid_idle", {s_k, s_tx}, {4'b0001, 32'h0000_00BC});
        chk("rst_mid_line", {20'h0, s_line}, 36'h0);
        fd_n = 0;
        for (int i = 0; i < 8; i++) begin
            step(0, 0, 1, 0);
            if (s_k == 4'b0001 && s_tx[7:0] == 8'hFD) fd_n++;
        end
        chk("rst_mid_no_eof", 36'(fd_n), 36'd0);

        // Randomized traffic against the reference schedule
        do_reset();
        for (int i = 0; i < 800; i++) begin
            if (fq.size() < 40 && $urandom_range(0, 3) != 0) fq.push_back($urandom());
            step($urandom_range(0, 199) == 0, $urandom_range(0, 29) == 0,
                 $urandom_range(0, 9) != 0, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hsst_fifo_pkt_tx.md
Name: hsst_fifo_pkt_tx

Overview:
- Read-side consumer of the HSST line FIFO. Drains fixed-length video line packets from the FIFO read port and frames them for the HSST transmit lane.
- Each packet is sent as SOF control word, then LINE_WORDS payload words, then EOF control word. The EOF word carries an XOR checksum.
- Emits the comma idle word when no packet is being sent.
- Single clock domain: the FIFO read clock.

Parameters:
- DATA_WIDTH, 32: payload and txdata width. Fixed at 32; the K-char layout assumes 4 bytes.
- DEPTH_WIDTH, 10: FIFO read depth width. The water level input is DEPTH_WIDTH+1 bits.
- LINE_WORDS, 640: payload words per packet. Legal range 1..2^DEPTH_WIDTH.

Ports:
- rd_clk  in  1  clock (FIFO read clock)
- rd_rst  in  1  reset, synchronous, active-high
- fifo_rd_en  out  1  FIFO read enable; data is valid the cycle after assertion
- fifo_rd_data  in  32  FIFO read data
- fifo_rd_empty  in  1  FIFO empty flag
- fifo_rd_water_level  in  DEPTH_WIDTH+1  FIFO read water level
- frame_start  in  1  one-cycle pulse; restarts the line numbering
- link_ready  in  1  HSST lane aligned; gates packet starts
- txdata  out  32  transmit word, registered
- txk  out  4  per-byte K flags, registered
- line_cnt  out  16  line number to be placed in the next SOF
- busy  out  1  high from start cycle through the EOF cycle
- underflow  out  1  sticky error flag

Behaviour:
- Reset is synchronous, active-high (rd_rst), one clock (rd_clk). Values while rd_rst is high and on the first cycle after release:
  - txdata=32'h0000_00BC, txk=4'b0001
  - fifo_rd_en=0 (gated low combinationally while rd_rst is high)
  - busy=0, underflow=0, line_cnt=0, checksum=0, FSM=IDLE
- Control words:
  - IDLE = {24'h0, 8'hBC}, txk=0001
  - SOF = {line_cnt, 8'h00, 8'hFB}, txk=0001
  - EOF = {chk[23:0], 8'hFD}, txk=0001
  - Payload words have txk=0000.
- Start condition at cycle S: FSM in IDLE or EOF state, link_ready=1, fifo_rd_water_level >= LINE_WORDS.
- Packet timing for a start at cycle S:
  - fifo_rd_en is high on cycles S .. S+LINE_WORDS-1, exactly LINE_WORDS cycles. It is combinational from the FSM and counter.
  - SOF appears on txdata at S+1.
  - Payload word k (k=0..LINE_WORDS-1) appears at S+2+k.
  - EOF appears at S+LINE_WORDS+2.
  - Latency is 2 cycles from fifo_rd_en to txdata: FIFO latency plus the output register.
- FSM states:
  - IDLE: on start go to SOF.
  - SOF: go to DATA.
  - DATA: stay for LINE_WORDS cycles, then go to EOF.
  - EOF: on start go to SOF, else go to IDLE.
  - The earliest next start is S+LINE_WORDS+2. Back-to-back packets therefore have no idle gap; minimum period is LINE_WORDS+2 cycles.
- Word counter: clog2(LINE_WORDS+1) bits; cleared on start; no wrap inside a packet.
- Checksum:
  - chk is cleared at SOF.
  - chk ^= fifo_rd_data for every payload word.
  - EOF carries the final value, bits [23:0].
- busy is high on cycles S .. S+LINE_WORDS+2.
- line_cnt:
  - Increments by 1 on each EOF cycle and wraps 16'hFFFF->0.
  - frame_start sets a pending flag. The flag forces line_cnt=0 on the next EOF or IDLE cycle, so a frame_start arriving mid-packet does not corrupt the SOF already sent.
  - frame_start coincident with an EOF: result is 0; frame_start wins.
- link_ready drops mid-packet: the packet completes unchanged; no new start occurs until link_ready is high again.
- Underflow: fifo_rd_en=1 while fifo_rd_empty=1 sets underflow=1, cleared only by rd_rst. The packet continues with whatever data the FIFO returns; length and framing are preserved.
- fifo_rd_water_level < LINE_WORDS: no start and no partial packets; IDLE words continue.
- rd_rst mid-packet: fifo_rd_en drops in the same cycle. The next txdata is IDLE and the packet is abandoned with no EOF. line_cnt, the pending flag and underflow clear.

Decomposition:
- Package hsst_pkt_pkg holds:
  - K-char constants K28_5=8'hBC, K27_7=8'hFB, K29_7=8'hFD
  - IDLE word
  - FSM state encoding {IDLE, SOF, DATA, EOF}
- No sub-module: FSM, counter, checksum and output register stay in one module of roughly 150-250 lines.

Test Plan (LINE_WORDS=4, DEPTH_WIDTH=10):
- Reset release, link_ready=1, water_level=3 -> txdata stays 32'h0000_00BC, txk=0001, fifo_rd_en=0 indefinitely.
- water_level=4, FIFO holds 1,2,3,4 -> fifo_rd_en high 4 cycles. txdata sequence: 32'h0000_00FB(k=0001), 1, 2, 3, 4 (k=0000), 32'h0000_04FD. line_cnt becomes 1.
- water_level=8 continuously, 8 words queued -> two packets back to back, no IDLE between. Second SOF = 32'h0001_00FB. fifo_rd_en low exactly 2 cycles between bursts.
- frame_start pulsed during DATA of line 5 -> that EOF is sent normally; the following SOF carries line 0 (32'h0000_00FB).
- fifo_rd_empty forced high during the 3rd read -> underflow=1 and held. EOF still at S+6. Subsequent packets are unaffected, and underflow stays 1 until rd_rst.
- rd_rst asserted at S+3 -> fifo_rd_en=0 the same cycle. txdata=32'h0000_00BC the next cycle; no EOF; line_cnt=0.
